seq_booth_multiplier: RTL
=========================

Name: seq_booth_multiplier

Overview:
Parametrised sequential radix-2 Booth multiplier with a start/done handshake and a run-time signed/unsigned mode select. It supersedes the fixed 4-bit combinational booth_multiplier for datapaths where area matters more than single-cycle latency. It retires one multiplier bit per clock and holds the registered product until the next operation completes.

Parameters:
WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits
CNT_W, $clog2(WIDTH+2), iteration counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
x  input  WIDTH  multiplicand; sampled with start
y  input  WIDTH  multiplier; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: z valid and updated
z  output  2*WIDTH  registered product

Behaviour:
- Clock/reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, z=0, all internal registers 0.
- States:
  - IDLE: on start=1, latch the operands, set busy=1 and go to CALC.
  - CALC: perform WIDTH+1 iterations, then return to IDLE.
  - There is no separate DONE state.
- Operand extension at accept: M and Q are WIDTH+1 bits.
  - signed_mode=1: sign-extend x and y.
  - signed_mode=0: zero-extend x and y.
  - A (WIDTH+1 bits) = 0, q_1 = 0, count = 0.
- Each CALC cycle:
  - {Q[0],q_1} = 01: A = A + M.
  - {Q[0],q_1} = 10: A = A - M.
  - 00 or 11: A unchanged.
  - Then arithmetic-shift {A,Q,q_1} right by one, replicating A's MSB. count increments.
- Width rules:
  - All add/sub is modulo 2^(WIDTH+1); overflow is impossible by construction.
  - z = low 2*WIDTH bits of {A,Q} after the final shift.
- Latency:
  - Start is accepted at edge E0; iterations occur at edges E1..E(WIDTH+1).
  - At edge E(WIDTH+1): z is loaded with the final product, done=1 for exactly one cycle, busy=0, state=IDLE.
  - Latency is identical in both modes.
- busy: high from the cycle after E0 through the cycle ending at E(WIDTH+1). It never overlaps done.
- start while busy: ignored. Operands and mode are not re-sampled.
- start high in the done cycle: accepted (state is IDLE). z keeps the previous product until the new done.
- start held high continuously: back-to-back operations, one every WIDTH+2 cycles.
- Operands changing after acceptance: no effect on the result.
- Reset mid-operation: immediate abort. All outputs return to reset values and no done is produced.
- z between operations: holds its value. It changes only on the done edge or on reset.

Decomposition:
- Shared package booth_pkg:
  - State encoding localparams ST_IDLE and ST_CALC.
  - Booth recoding constants: BOOTH_NOP, BOOTH_ADD, BOOTH_SUB.
- One sub-module, booth_step:
  - Combinational; parametrised on WIDTH+1.
  - Takes A, Q, q_1 and M.
  - Returns the next A, Q and q_1 (recoded add/sub plus arithmetic shift).
  - Instantiated once; the top holds the FSM, counter and registers.

Test Plan:
1. WIDTH=4, signed_mode=1, x=0101, y=0101, pulse start -> after 5 iterations: done pulse, z=8'h19, busy low in the done cycle.
2. WIDTH=4, signed: x=1000, y=1000 -> z=8'h40. Then x=1000, y=0111 -> z=8'hC8 (-56). Then x=1111, y=1111 -> z=8'h01.
3. WIDTH=4, signed_mode=0, x=1111, y=1111 -> z=8'hE1 (225). Same operands with signed_mode=1 -> z=8'h01.
4. WIDTH=8, signed: x=8'h80, y=8'h80 -> z=16'h4000. Unsigned x=8'hFF, y=8'hFF -> z=16'hFE01. done occurs exactly 9 edges after the accepting edge.
5. WIDTH=4: start 5*3, then pulse start with 7*7 while busy -> single done with z=8'h0F; the second request is ignored. Then hold start high for two operations -> dones 6 cycles apart.
6. WIDTH=4: start 5*5, assert rst_n=0 mid-CALC -> busy=0, done=0, z=0 immediately. Release reset -> IDLE; a fresh 2*3 gives z=8'h06.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier: FSM states
// and the Booth recoding of the (Q[0], q_1) bit pair.
package booth_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_CALC = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      BOOTH_NOP = 2'd0,
      BOOTH_ADD = 2'd1,
      BOOTH_SUB = 2'd2
   } booth_op_e;

   function automatic booth_op_e booth_recode(input logic q0, input logic q_1);
      case ({q0, q_1})
         2'b01:   return BOOTH_ADD;
         2'b10:   return BOOTH_SUB;
         default: return BOOTH_NOP;
      endcase
   endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: recoded add/subtract of M into A, followed by
// an arithmetic right shift of {A, Q, q_1}.
module booth_step
   import booth_pkg::*;
#(
   parameter int W = 9
) (
   input  logic signed [W-1:0] a,
   input  logic        [W-1:0] q,
   input  logic                q_1,
   input  logic signed [W-1:0] m,
   output logic signed [W-1:0] a_next,
   output logic        [W-1:0] q_next,
   output logic                q_1_next
);

   logic signed [W-1:0] sum;

   always_comb begin
      case (booth_recode(q[0], q_1))
         BOOTH_ADD: sum = a + m;
         BOOTH_SUB: sum = a - m;
         default:   sum = a;
      endcase
      // Sign bit of the partial sum is replicated; its LSB moves into Q.
      a_next   = sum >>> 1;
      q_next   = {sum[0], q[W-1:1]};
      q_1_next = q[0];
   end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-2 Booth multiplier, one multiplier bit per clock, with a
// start/done handshake and run-time signed/unsigned operand selection.
module seq_booth_multiplier
   import booth_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 2)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] z
);

   localparam int EW = WIDTH + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

   state_e               state, state_next;
   logic signed [EW-1:0] a, m, a_step;
   logic        [EW-1:0] q, q_step;
   logic                 q_1, q_1_step;
   logic [CNT_W-1:0]     count;
   logic                 accept, last;

   booth_step #(.W(EW)) u_step (
      .a        (a),
      .q        (q),
      .q_1      (q_1),
      .m        (m),
      .a_next   (a_step),
      .q_next   (q_step),
      .q_1_next (q_1_step)
   );

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      last       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = ST_CALC;
            end
         end
         ST_CALC: begin
            if (count == LAST) begin
               last       = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Operands are extended by one bit so unsigned values stay positive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a     <= '0;
         m     <= '0;
         q     <= '0;
         q_1   <= 1'b0;
         count <= '0;
         done  <= 1'b0;
         z     <= '0;
      end else begin
         done <= last;
         if (accept) begin
            m     <= {signed_mode & x[WIDTH-1], x};
            q     <= {signed_mode & y[WIDTH-1], y};
            a     <= '0;
            q_1   <= 1'b0;
            count <= '0;
         end else if (state == ST_CALC) begin
            a     <= a_step;
            q     <= q_step;
            q_1   <= q_1_step;
            count <= count + CNT_W'(1);
            if (last) z <= {a_step[WIDTH-2:0], q_step};
         end
      end
   end

   assign busy = (state == ST_CALC);

endmodule
